// File: rtl/rr_mux_sched.sv
// ---------------------------------------------------------------------------
// rr_mux_sched
//   Round-robin scheduler sharing one 8:1 mux output among 8 requesters.
//   A winner keeps the grant while it keeps requesting, for at most MAX_HOLD
//   consecutive cycles. After that the grant rotates to the next requester.
//
//   Parameters
//     MAX_HOLD  max consecutive grant cycles per winner (1..15)
//     HOLD_W    width of the hold counter (must be able to hold MAX_HOLD)
//
//   Ports
//     clk    in   clock, all state on the rising edge
//     rst    in   synchronous reset, active-high
//     en     in   scheduler enable; low drops the current grant
//     req    in   [7:0] request per requester
//     in     in   [7:0] data bit per requester (mux data inputs)
//     gnt    out  [7:0] registered one-hot grant, zero when idle
//     sel    out  [2:0] registered mux select (index of the gnt bit)
//     out    out  in[sel] while valid, else 0 (combinational)
//     valid  out  high while a grant is active
//     busy   out  valid | (|req & en) (combinational)
// ---------------------------------------------------------------------------
module rr_mux_sched #(
    parameter int MAX_HOLD = 4,
    parameter int HOLD_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    input  logic [7:0] in,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       out,
    output logic       valid,
    output logic       busy
);

    localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        gnt_q,   gnt_d;
    logic [2:0]        sel_q,   sel_d;
    logic [2:0]        ptr_q,   ptr_d;
    logic [HOLD_W-1:0] cnt_q,   cnt_d;

    // {found, index} of the first request at or after 'start', wrapping 7->0.
    logic [3:0] pick_ptr;
    logic [3:0] pick_next;

    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] start);
        logic       found;
        logic [2:0] idx;
        logic [2:0] cand;
        found = 1'b0;
        idx   = start;
        for (int k = 0; k < 8; k++) begin
            cand = start + 3'(k);
            if (!found && r[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    function automatic logic [7:0] onehot(input logic [2:0] i);
        return 8'b0000_0001 << i;
    endfunction

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        pick_ptr  = rr_pick(req, ptr_q);
        // Scanning from sel+1 puts the current holder last, so a sole
        // requester at forced rotation simply gets re-granted.
        pick_next = rr_pick(req, sel_q + 3'd1);

        case (state_q)
            IDLE: begin
                gnt_d = 8'h00;
                if (en && (|req)) begin
                    state_d = GRANT;
                    gnt_d   = onehot(pick_ptr[2:0]);
                    sel_d   = pick_ptr[2:0];
                    cnt_d   = HOLD_W'(1);
                end
            end
            GRANT: begin
                if (!en) begin
                    state_d = IDLE;
                    gnt_d   = 8'h00;
                    ptr_d   = sel_q + 3'd1;
                end else if (!req[sel_q]) begin
                    // Release: hand over directly, no idle bubble.
                    ptr_d = sel_q + 3'd1;
                    if (pick_next[3]) begin
                        gnt_d = onehot(pick_next[2:0]);
                        sel_d = pick_next[2:0];
                        cnt_d = HOLD_W'(1);
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 8'h00;
                    end
                end else if (cnt_q == MAX_HOLD_C) begin
                    // Forced rotation; req[sel] is set so a winner always exists.
                    ptr_d = sel_q + 3'd1;
                    gnt_d = onehot(pick_next[2:0]);
                    sel_d = pick_next[2:0];
                    cnt_d = HOLD_W'(1);
                end else begin
                    cnt_d = cnt_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 8'h00;
            sel_q   <= 3'd0;
            ptr_q   <= 3'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt   = gnt_q;
    assign sel   = sel_q;
    assign valid = (state_q == GRANT);
    assign out   = valid ? in[sel_q] : 1'b0;
    assign busy  = valid | ((|req) & en);

endmodule

// File: tb/tb_rr_mux_sched.sv
module tb_rr_mux_sched;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [7:0] in;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       out;
    logic       valid;
    logic       busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       valid;
        logic       out;
        logic       busy;
    } exp_t;

    exp_t sbq[$];

    rr_mux_sched #(.MAX_HOLD(4), .HOLD_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .req   (req),
        .in    (in),
        .gnt   (gnt),
        .sel   (sel),
        .out   (out),
        .valid (valid),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Drive one cycle of inputs, push the expected post-edge outputs, then
    // pop and compare one step after the rising edge.
    task automatic cyc(input string tag, input logic rs, input logic e,
                       input logic [7:0] r, input logic [7:0] d,
                       input logic [7:0] eg, input logic [2:0] es,
                       input logic ev, input logic eo);
        exp_t x;
        exp_t y;
        rst = rs;
        en  = e;
        req = r;
        in  = d;
        x.gnt   = eg;
        x.sel   = es;
        x.valid = ev;
        x.out   = eo;
        x.busy  = ev | ((|r) & e);
        sbq.push_back(x);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            chk({tag, "_sbq_empty"}, 8'd0, 8'd1);
        end else begin
            y = sbq.pop_front();
            chk({tag, "_gnt"},   gnt,         y.gnt);
            chk({tag, "_sel"},   {5'd0, sel}, {5'd0, y.sel});
            chk({tag, "_valid"}, {7'd0, valid}, {7'd0, y.valid});
            chk({tag, "_out"},   {7'd0, out},   {7'd0, y.out});
            chk({tag, "_busy"},  {7'd0, busy},  {7'd0, y.busy});
        end
    endtask

    // Combinational check between edges: change inputs, no clock edge.
    task automatic comb(input string tag, input logic e, input logic [7:0] r,
                        input logic [7:0] d, input logic eo, input logic eb);
        en  = e;
        req = r;
        in  = d;
        #1;
        chk({tag, "_out"},  {7'd0, out},  {7'd0, eo});
        chk({tag, "_busy"}, {7'd0, busy}, {7'd0, eb});
    endtask

    initial begin
        logic [2:0] es;
        logic [7:0] din;
        clk = 1'b0;
        rst = 1'b1;
        en  = 1'b0;
        req = 8'h00;
        in  = 8'h00;

        // T1 reset with all requests pending
        cyc("t1_rst0", 1'b1, 1'b1, 8'hFF, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0);
        cyc("t1_rst1", 1'b1, 1'b1, 8'hFF, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0);
        cyc("t1_first", 1'b0, 1'b1, 8'hFF, 8'h01, 8'h01, 3'd0, 1'b1, 1'b1);
        cyc("t1_rel", 1'b0, 1'b1, 8'h00, 8'h01, 8'h00, 3'd0, 1'b0, 1'b0);

        // T2 single requester held across forced rotations
        cyc("t2_gnt", 1'b0, 1'b1, 8'h08, 8'h08, 8'h08, 3'd3, 1'b1, 1'b1);
        for (int k = 0; k < 8; k++)
            cyc("t2_hold", 1'b0, 1'b1, 8'h08, 8'h08, 8'h08, 3'd3, 1'b1, 1'b1);
        cyc("t2_drop", 1'b0, 1'b1, 8'h00, 8'h08, 8'h00, 3'd3, 1'b0, 1'b0);

        // T3 fair rotation with all requesting, starting from pointer 0
        cyc("t3_rst", 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        din = 8'hAA;
        for (int k = 0; k < 36; k++) begin
            es = 3'((k / 4) % 8);
            cyc("t3_rot", 1'b0, 1'b1, 8'hFF, din, 8'h01 << es, es, 1'b1, din[es]);
        end

        // T4 early release of 7 wraps to 0 without a bubble
        cyc("t4_rst", 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        cyc("t4_g7", 1'b0, 1'b1, 8'h80, 8'h81, 8'h80, 3'd7, 1'b1, 1'b1);
        cyc("t4_g7b", 1'b0, 1'b1, 8'h81, 8'h81, 8'h80, 3'd7, 1'b1, 1'b1);
        cyc("t4_wrap", 1'b0, 1'b1, 8'h01, 8'h81, 8'h01, 3'd0, 1'b1, 1'b1);
        cyc("t4_hold", 1'b0, 1'b1, 8'h01, 8'h81, 8'h01, 3'd0, 1'b1, 1'b1);
        cyc("t4_idle", 1'b0, 1'b1, 8'h00, 8'h81, 8'h00, 3'd0, 1'b0, 1'b0);

        // T5 data path follows in[sel] combinationally; pointer is 1 here
        cyc("t5_g5", 1'b0, 1'b1, 8'h20, 8'h20, 8'h20, 3'd5, 1'b1, 1'b1);
        cyc("t5_lo", 1'b0, 1'b1, 8'h20, 8'h00, 8'h20, 3'd5, 1'b1, 1'b0);
        comb("t5_c_hi", 1'b1, 8'h20, 8'h20, 1'b1, 1'b1);
        comb("t5_c_b4", 1'b1, 8'h20, 8'h10, 1'b0, 1'b1);
        comb("t5_c_ef", 1'b1, 8'h20, 8'hDF, 1'b0, 1'b1);
        cyc("t5_b4", 1'b0, 1'b1, 8'h20, 8'h10, 8'h20, 3'd5, 1'b1, 1'b0);
        cyc("t5_hi", 1'b0, 1'b1, 8'h20, 8'h30, 8'h20, 3'd5, 1'b1, 1'b1);
        cyc("t5_rot", 1'b0, 1'b1, 8'h20, 8'h20, 8'h20, 3'd5, 1'b1, 1'b1);
        cyc("t5_idle", 1'b0, 1'b1, 8'h00, 8'h20, 8'h00, 3'd5, 1'b0, 1'b0);
        comb("t5_idle_busy", 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b1);
        comb("t5_idle_en0", 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0);
        cyc("t5_en0", 1'b0, 1'b0, 8'hFF, 8'hFF, 8'h00, 3'd5, 1'b0, 1'b0);

        // T6 enable abort, pointer past 2, then reset mid-grant
        cyc("t6_g2", 1'b0, 1'b1, 8'h04, 8'h04, 8'h04, 3'd2, 1'b1, 1'b1);
        cyc("t6_g2b", 1'b0, 1'b1, 8'h04, 8'h04, 8'h04, 3'd2, 1'b1, 1'b1);
        cyc("t6_abort", 1'b0, 1'b0, 8'h04, 8'h04, 8'h00, 3'd2, 1'b0, 1'b0);
        cyc("t6_wrap", 1'b0, 1'b1, 8'h05, 8'h05, 8'h01, 3'd0, 1'b1, 1'b1);
        cyc("t6_rst", 1'b1, 1'b1, 8'h05, 8'h05, 8'h00, 3'd0, 1'b0, 1'b0);
        cyc("t6_after", 1'b0, 1'b1, 8'h00, 8'h05, 8'h00, 3'd0, 1'b0, 1'b0);

        chk("sbq_drained", 8'(sbq.size()), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
